// File: rtl/qos_pkg.sv
// qos_pkg: width helpers, default constants and the queue-selection helper
// shared by the QoS scheduler and its optional serial entry front end.
package qos_pkg;

  localparam int MAX_Q         = 8;
  localparam int CNT_W_DEFAULT = 7;

  function automatic int qid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int depth_w(input int d);
    return $clog2(d + 1);
  endfunction

  function automatic int tick_w(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

  function automatic int total_w(input int cw, input int n);
    return cw + qid_w(n);
  endfunction

  // Urgent queues win, highest index first; otherwise lowest non-empty index.
  function automatic int qos_select(input logic [MAX_Q-1:0] urg,
                                    input logic [MAX_Q-1:0] nonempty);
    int pick;
    pick = 0;
    if (|urg) begin
      for (int i = 0; i < MAX_Q; i++)
        if (urg[i]) pick = i;
    end else begin
      for (int i = MAX_Q - 1; i >= 0; i--)
        if (nonempty[i]) pick = i;
    end
    return pick;
  endfunction

endpackage

// File: rtl/qos_serial_entry.sv
// qos_serial_entry: builds packets bit by bit from two debounced active-low
// buttons (MSB first, qid in the top bits). Only compiled when
// QOS_SERIAL_IN_EN is defined.
`ifdef QOS_SERIAL_IN_EN
module qos_serial_entry #(
  parameter int QW     = 2,
  parameter int DATA_W = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_btn_zero_n,
  input  logic              i_btn_one_n,
  input  logic              i_start_n,
  output logic              o_pkt_valid,
  output logic [QW-1:0]     o_pkt_qid,
  output logic [DATA_W-1:0] o_pkt_data
);
  localparam int PW = QW + DATA_W;
  localparam int BW = $clog2(PW + 1);

  logic          r_zero_d, r_one_d, r_valid;
  logic [PW-1:0] r_shift, r_pkt;
  logic [BW-1:0] r_bits;
  logic          w_fall0, w_fall1, w_bit;
  logic [PW-1:0] w_next;

  // Edge detect; a simultaneous press of both buttons counts as a zero.
  always_comb begin
    w_fall0 = r_zero_d & ~i_btn_zero_n;
    w_fall1 = r_one_d & ~i_btn_one_n;
    w_bit   = ~w_fall0;
    w_next  = {r_shift[PW-2:0], w_bit};
  end

  // Shift register and bit counter; issues a packet after PW bits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_zero_d <= 1'b1;
      r_one_d  <= 1'b1;
      r_shift  <= '0;
      r_pkt    <= '0;
      r_bits   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_zero_d <= i_btn_zero_n;
      r_one_d  <= i_btn_one_n;
      r_valid  <= 1'b0;
      if (!i_start_n) begin
        r_shift <= '0;
        r_bits  <= '0;
      end else if (w_fall0 || w_fall1) begin
        if (r_bits == BW'(PW - 1)) begin
          r_pkt   <= w_next;
          r_valid <= 1'b1;
          r_shift <= '0;
          r_bits  <= '0;
        end else begin
          r_shift <= w_next;
          r_bits  <= r_bits + BW'(1);
        end
      end
    end
  end

  assign o_pkt_valid = r_valid;
  assign o_pkt_qid   = r_pkt[PW-1 -: QW];
  assign o_pkt_data  = r_pkt[DATA_W-1:0];

endmodule
`endif

// File: rtl/qos_priority_scheduler.sv
// qos_priority_scheduler: NUM_Q class FIFOs with drop-oldest overflow, one
// release per TX_PERIOD, urgency pre-emption and per-queue statistics.
// Define QOS_SERIAL_IN_EN to replace the parallel packet port with the
// button-driven serial entry front end.
module qos_priority_scheduler
  import qos_pkg::*;
#(
  parameter int NUM_Q      = 4,
  parameter int DEPTH      = 6,
  parameter int DATA_W     = 2,
  parameter int URGENT_LVL = 5,
  parameter int TX_PERIOD  = 150000000,
  parameter int CNT_W      = 7
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
`ifdef QOS_SERIAL_IN_EN
  input  logic                               i_btn_zero_n,
  input  logic                               i_btn_one_n,
  input  logic                               i_start_n,
`else
  input  logic                               i_in_valid,
  input  logic [qid_w(NUM_Q)-1:0]            i_in_qid,
  input  logic [DATA_W-1:0]                  i_in_data,
`endif
  input  logic                               i_tx_ready,
  output logic                               o_tx_valid,
  output logic [qid_w(NUM_Q)-1:0]            o_tx_qid,
  output logic [DATA_W-1:0]                  o_tx_data,
  output logic [NUM_Q*depth_w(DEPTH)-1:0]    o_depth,
  output logic [NUM_Q*DEPTH*DATA_W-1:0]      o_q_flat,
  output logic [NUM_Q*CNT_W-1:0]             o_rx_cnt,
  output logic [NUM_Q*CNT_W-1:0]             o_tx_cnt,
  output logic [NUM_Q*CNT_W-1:0]             o_drop_cnt,
  output logic [total_w(CNT_W, NUM_Q)-1:0]   o_total_rx,
  output logic [total_w(CNT_W, NUM_Q)-1:0]   o_total_tx,
  output logic [total_w(CNT_W, NUM_Q)-1:0]   o_total_drop
);
  localparam int QW   = qid_w(NUM_Q);
  localparam int DW   = depth_w(DEPTH);
  localparam int TW   = tick_w(TX_PERIOD);
  localparam int TOTW = total_w(CNT_W, NUM_Q);

  logic [DATA_W-1:0] r_q      [NUM_Q][DEPTH];
  logic [DATA_W-1:0] w_q_nxt  [NUM_Q][DEPTH];
  logic [DW-1:0]     r_depth  [NUM_Q];
  logic [DW-1:0]     w_depth_nxt [NUM_Q];
  logic [CNT_W-1:0]  r_rx [NUM_Q];
  logic [CNT_W-1:0]  r_tx [NUM_Q];
  logic [CNT_W-1:0]  r_drop [NUM_Q];
  logic [TW-1:0]     r_tick;
  logic              r_pending, r_tx_valid;
  logic [QW-1:0]     r_tx_qid;
  logic [DATA_W-1:0] r_tx_data;
  logic [TOTW-1:0]   r_total_rx, r_total_tx, r_total_drop;

  logic              w_arr_valid;
  logic [QW-1:0]     w_arr_qid;
  logic [DATA_W-1:0] w_arr_data;
  logic [NUM_Q-1:0]  w_urg, w_ne, w_full, w_push, w_pop, w_drop;
  logic [QW-1:0]     w_sel;
  logic              w_deq, w_tick_end;
  logic [TOTW-1:0]   w_sum_rx, w_sum_tx, w_sum_drop;

`ifdef QOS_SERIAL_IN_EN
  qos_serial_entry #(.QW(QW), .DATA_W(DATA_W)) u_entry (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_btn_zero_n (i_btn_zero_n),
    .i_btn_one_n  (i_btn_one_n),
    .i_start_n    (i_start_n),
    .o_pkt_valid  (w_arr_valid),
    .o_pkt_qid    (w_arr_qid),
    .o_pkt_data   (w_arr_data)
  );
`else
  assign w_arr_valid = i_in_valid;
  assign w_arr_qid   = i_in_qid;
  assign w_arr_data  = i_in_data;
`endif

  // Queue status flags and the service choice, all from pre-edge depths.
  always_comb begin
    w_urg  = '0;
    w_ne   = '0;
    w_full = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      w_urg[i]  = r_depth[i] >= DW'(URGENT_LVL);
      w_ne[i]   = r_depth[i] != '0;
      w_full[i] = r_depth[i] == DW'(DEPTH);
    end
    w_sel      = QW'(qos_select(MAX_Q'(w_urg), MAX_Q'(w_ne)));
    w_deq      = r_pending && i_tx_ready && (|w_ne);
    w_tick_end = r_tick == TW'(TX_PERIOD - 1);
  end

  // Next queue contents: pop shifts toward the head, push lands at the tail,
  // a push into a full queue without a pop evicts the head.
  always_comb begin
    w_q_nxt     = r_q;
    w_depth_nxt = r_depth;
    w_push      = '0;
    w_pop       = '0;
    w_drop      = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      w_push[i] = w_arr_valid && (w_arr_qid == QW'(i));
      w_pop[i]  = w_deq && (w_sel == QW'(i));
      w_drop[i] = w_push[i] && !w_pop[i] && w_full[i];
      if (w_pop[i] || w_drop[i]) begin
        for (int j = 0; j < DEPTH - 1; j++) w_q_nxt[i][j] = r_q[i][j+1];
        w_q_nxt[i][DEPTH-1] = '0;
      end
      if (w_push[i]) begin
        for (int j = 0; j < DEPTH; j++)
          if (DW'(j) == ((w_pop[i] || w_full[i]) ? r_depth[i] - DW'(1) : r_depth[i]))
            w_q_nxt[i][j] = w_arr_data;
      end
      if (w_pop[i] && !w_push[i])
        w_depth_nxt[i] = r_depth[i] - DW'(1);
      else if (w_push[i] && !w_pop[i] && !w_full[i])
        w_depth_nxt[i] = r_depth[i] + DW'(1);
    end
  end

  // Queue storage and per-queue statistics.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_Q; i++) begin
        for (int j = 0; j < DEPTH; j++) r_q[i][j] <= '0;
        r_depth[i] <= '0;
        r_rx[i]    <= '0;
        r_tx[i]    <= '0;
        r_drop[i]  <= '0;
      end
    end else begin
      r_q     <= w_q_nxt;
      r_depth <= w_depth_nxt;
      for (int i = 0; i < NUM_Q; i++) begin
        r_rx[i]   <= r_rx[i] + CNT_W'(w_push[i]);
        r_tx[i]   <= r_tx[i] + CNT_W'(w_pop[i]);
        r_drop[i] <= r_drop[i] + CNT_W'(w_drop[i]);
      end
    end
  end

  // Transmit period timer, single outstanding request, registered tx outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tick     <= '0;
      r_pending  <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_qid   <= '0;
      r_tx_data  <= '0;
    end else begin
      r_tick <= w_tick_end ? '0 : r_tick + TW'(1);
      if (w_tick_end)
        r_pending <= 1'b1;
      else if (r_pending && (i_tx_ready || !(|w_ne)))
        r_pending <= 1'b0;
      r_tx_valid <= w_deq;
      if (w_deq) begin
        r_tx_qid  <= w_sel;
        r_tx_data <= r_q[w_sel][0];
      end
    end
  end

  // Statistic totals, summed from the registered per-queue counters.
  always_comb begin
    w_sum_rx   = '0;
    w_sum_tx   = '0;
    w_sum_drop = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      w_sum_rx   = w_sum_rx + TOTW'(r_rx[i]);
      w_sum_tx   = w_sum_tx + TOTW'(r_tx[i]);
      w_sum_drop = w_sum_drop + TOTW'(r_drop[i]);
    end
  end

  // Totals are registered, so they trail the per-queue counters by a cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_total_rx   <= '0;
      r_total_tx   <= '0;
      r_total_drop <= '0;
    end else begin
      r_total_rx   <= w_sum_rx;
      r_total_tx   <= w_sum_tx;
      r_total_drop <= w_sum_drop;
    end
  end

  // Flatten internal arrays onto the packed status outputs.
  always_comb begin
    o_depth    = '0;
    o_q_flat   = '0;
    o_rx_cnt   = '0;
    o_tx_cnt   = '0;
    o_drop_cnt = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      o_depth[i*DW +: DW]          = r_depth[i];
      o_rx_cnt[i*CNT_W +: CNT_W]   = r_rx[i];
      o_tx_cnt[i*CNT_W +: CNT_W]   = r_tx[i];
      o_drop_cnt[i*CNT_W +: CNT_W] = r_drop[i];
      for (int j = 0; j < DEPTH; j++)
        o_q_flat[(i*DEPTH + j)*DATA_W +: DATA_W] = r_q[i][j];
    end
  end

  assign o_tx_valid   = r_tx_valid;
  assign o_tx_qid     = r_tx_qid;
  assign o_tx_data    = r_tx_data;
  assign o_total_rx   = r_total_rx;
  assign o_total_tx   = r_total_tx;
  assign o_total_drop = r_total_drop;

endmodule
